// File: rtl/sensor_regs_pkg.sv
// sensor_regs_pkg: channel state types, register map constants and byte-merge helper for the sensor register slave
package sensor_regs_pkg;
  typedef enum logic [1:0] {W_IDLE, W_COMMIT, W_RESP} wstate_e;
  typedef enum logic {R_IDLE, R_DATA} rstate_e;
  localparam int NUM_REGS = 4;
  localparam logic [3:0] REG0_OFS = 4'h0;
  localparam logic [3:0] REG1_OFS = 4'h4;
  localparam logic [3:0] REG2_OFS = 4'h8;
  localparam logic [3:0] REG3_OFS = 4'hC;
  localparam logic [1:0] RESP_OKAY = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  function automatic logic [31:0] apply_wstrb(input logic [31:0] old_val, input logic [31:0] wdata, input logic [3:0] wstrb);
    logic [31:0] m;
    for (int b = 0; b < 4; b++) m[8*b +: 8] = wstrb[b] ? wdata[8*b +: 8] : old_val[8*b +: 8];
    return m;
  endfunction
endpackage

// File: rtl/axi4lite_sensor_regs_slv.sv
// axi4lite_sensor_regs_slv: AXI4-Lite slave with four control registers; SENSOR_REGS_SLVERR_EN makes upper address bits unmapped
module axi4lite_sensor_regs_slv
  import sensor_regs_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4,
  parameter int NUM_REGS = sensor_regs_pkg::NUM_REGS
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic [2:0]                      s_axi_awprot,
  input  logic                            s_axi_awvalid,
  output logic                            s_axi_awready,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s_axi_wstrb,
  input  logic                            s_axi_wvalid,
  output logic                            s_axi_wready,
  output logic [1:0]                      s_axi_bresp,
  output logic                            s_axi_bvalid,
  input  logic                            s_axi_bready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic [2:0]                      s_axi_arprot,
  input  logic                            s_axi_arvalid,
  output logic                            s_axi_arready,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_rdata,
  output logic [1:0]                      s_axi_rresp,
  output logic                            s_axi_rvalid,
  input  logic                            s_axi_rready,
  output logic [NUM_REGS*32-1:0]          reg_q,
  output logic [NUM_REGS-1:0]             reg_wr_stb
);
  wstate_e r_wstate, w_wnext;
  rstate_e r_rstate, w_rnext;
  logic [31:0] r_regs [NUM_REGS];
  logic [C_S_AXI_ADDR_WIDTH-1:0] r_awaddr;
  logic [C_S_AXI_DATA_WIDTH-1:0] r_wdata, r_rdata;
  logic [C_S_AXI_DATA_WIDTH/8-1:0] r_wstrb;
  logic [NUM_REGS-1:0] r_wr_stb;
  logic [1:0] r_bresp, r_rresp;
  logic r_awready, r_wready, r_arready, r_aw_got, r_w_got;
  logic w_aw_hs, w_w_hs, w_ar_hs, w_aw_ok, w_ar_ok, w_unused;
  logic [1:0] w_widx, w_ridx;
  assign w_aw_hs = s_axi_awvalid && r_awready;
  assign w_w_hs = s_axi_wvalid && r_wready;
  assign w_ar_hs = s_axi_arvalid && r_arready;
  assign w_widx = r_awaddr[3:2];
  assign w_ridx = s_axi_araddr[3:2];
`ifdef SENSOR_REGS_SLVERR_EN
  assign w_aw_ok = (r_awaddr >> 4) == '0;
  assign w_ar_ok = (s_axi_araddr >> 4) == '0;
`else
  assign w_aw_ok = 1'b1;
  assign w_ar_ok = 1'b1;
`endif
  assign w_unused = ^{s_axi_awprot, s_axi_arprot, r_awaddr, s_axi_araddr};
  assign s_axi_awready = r_awready;
  assign s_axi_wready = r_wready;
  assign s_axi_arready = r_arready;
  assign s_axi_bvalid = r_wstate == W_RESP;
  assign s_axi_bresp = r_bresp;
  assign s_axi_rvalid = r_rstate == R_DATA;
  assign s_axi_rdata = r_rdata;
  assign s_axi_rresp = r_rresp;
  assign reg_wr_stb = r_wr_stb;
  for (genvar n = 0; n < NUM_REGS; n++) begin : g_q
    assign reg_q[32*n +: 32] = r_regs[n];
  end
  // channel state registers
  always_ff @(posedge clock) begin
    if (reset) begin
      r_wstate <= W_IDLE;
      r_rstate <= R_IDLE;
    end else begin
      r_wstate <= w_wnext;
      r_rstate <= w_rnext;
    end
  end
  // write commits only once both halves are latched; read leaves R_DATA on rready
  always_comb begin
    w_wnext = r_wstate == W_IDLE ? (r_aw_got && r_w_got ? W_COMMIT : W_IDLE) :
              r_wstate == W_COMMIT ? W_RESP : (s_axi_bready ? W_IDLE : W_RESP);
    w_rnext = r_rstate == R_IDLE ? (w_ar_hs ? R_DATA : R_IDLE) : (s_axi_rready ? R_IDLE : R_DATA);
  end
  // handshake capture, register update and read capture (read sees pre-commit contents)
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
      r_awaddr <= '0;
      r_wdata <= '0;
      r_wstrb <= '0;
      r_rdata <= '0;
      r_bresp <= RESP_OKAY;
      r_rresp <= RESP_OKAY;
      r_wr_stb <= '0;
      r_awready <= 1'b0;
      r_wready <= 1'b0;
      r_arready <= 1'b0;
      r_aw_got <= 1'b0;
      r_w_got <= 1'b0;
    end else begin
      r_awready <= r_wstate == W_IDLE && !r_aw_got && !r_awready && s_axi_awvalid;
      r_wready <= r_wstate == W_IDLE && !r_w_got && !r_wready && s_axi_wvalid;
      r_arready <= r_rstate == R_IDLE && !r_arready && s_axi_arvalid;
      if (w_aw_hs) begin
        r_awaddr <= s_axi_awaddr;
        r_aw_got <= 1'b1;
      end
      if (w_w_hs) begin
        r_wdata <= s_axi_wdata;
        r_wstrb <= s_axi_wstrb;
        r_w_got <= 1'b1;
      end
      r_wr_stb <= '0;
      if (r_wstate == W_COMMIT) begin
        r_aw_got <= 1'b0;
        r_w_got <= 1'b0;
        r_bresp <= w_aw_ok ? RESP_OKAY : RESP_SLVERR;
        if (w_aw_ok) begin
          r_regs[w_widx] <= apply_wstrb(r_regs[w_widx], r_wdata, r_wstrb);
          r_wr_stb[w_widx] <= 1'b1;
        end
      end
      if (w_ar_hs) begin
        r_rdata <= w_ar_ok ? r_regs[w_ridx] : '0;
        r_rresp <= w_ar_ok ? RESP_OKAY : RESP_SLVERR;
      end
    end
  end
endmodule

// File: tb/tb_axi4lite_sensor_regs_slv.sv
// tb_axi4lite_sensor_regs_slv: scoreboard bench for the sensor register slave (model follows SENSOR_REGS_SLVERR_EN)
module tb_axi4lite_sensor_regs_slv;
  localparam int AW = 6;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [AW-1:0] s_axi_awaddr = '0, s_axi_araddr = '0;
  logic [2:0] s_axi_awprot = '0, s_axi_arprot = '0;
  logic s_axi_awvalid = 0, s_axi_wvalid = 0, s_axi_bready = 1, s_axi_arvalid = 0, s_axi_rready = 1;
  logic [31:0] s_axi_wdata = '0;
  logic [3:0] s_axi_wstrb = '0;
  logic s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_arready, s_axi_rvalid;
  logic [1:0] s_axi_bresp, s_axi_rresp;
  logic [31:0] s_axi_rdata;
  logic [127:0] reg_q;
  logic [3:0] reg_wr_stb;
  int checks = 0, errors = 0;
  logic [31:0] model [4];
  logic [1:0] exp_b_q [$];
  logic [33:0] exp_r_q [$];
  int stb_cnt [4], exp_stb [4];
  int b_rise = 0, exp_writes = 0, last_ar_n = 0;
  logic prev_bvalid = 0, last_rv = 0;
  always #5 clk = ~clk;
  axi4lite_sensor_regs_slv #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(AW), .NUM_REGS(4)) dut (
    .clock(clk), .reset(rst),
    .s_axi_awaddr(s_axi_awaddr), .s_axi_awprot(s_axi_awprot), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
    .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
    .s_axi_araddr(s_axi_araddr), .s_axi_arprot(s_axi_arprot), .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
    .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp), .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
    .reg_q(reg_q), .reg_wr_stb(reg_wr_stb)
  );
  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  function automatic bit mapped(input logic [AW-1:0] a);
`ifdef SENSOR_REGS_SLVERR_EN
    return a[AW-1:4] == '0;
`else
    return 1'b1;
`endif
  endfunction
  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] mask = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    return (o & ~mask) | (d & mask);
  endfunction
  // monitor: pops expectations when the DUT completes a response; counts strobes and bvalid rises
  always @(negedge clk) if (!rst) begin
    if (s_axi_bvalid && s_axi_bready) begin
      if (exp_b_q.size() == 0) check("b_unexpected", 1, 0);
      else check("bresp", s_axi_bresp, exp_b_q.pop_front());
    end
    if (s_axi_rvalid && s_axi_rready) begin
      if (exp_r_q.size() == 0) check("r_unexpected", 1, 0);
      else check("rresp_rdata", {s_axi_rresp, s_axi_rdata}, exp_r_q.pop_front());
    end
    for (int i = 0; i < 4; i++) if (reg_wr_stb[i]) stb_cnt[i]++;
    if (s_axi_bvalid && !prev_bvalid) b_rise++;
    prev_bvalid = s_axi_bvalid;
  end
  task automatic drive_aw(input logic [AW-1:0] a, input int dly);
    repeat (dly) @(negedge clk);
    s_axi_awaddr = a;
    s_axi_awvalid = 1;
    for (int n = 0; n <= 100; n++) begin
      @(negedge clk);
      if (s_axi_awready) break;
      if (n == 100) check("aw_timeout", 0, 1);
    end
    @(negedge clk);
    s_axi_awvalid = 0;
  endtask
  task automatic drive_w(input logic [31:0] d, input logic [3:0] s, input int dly);
    repeat (dly) @(negedge clk);
    s_axi_wdata = d;
    s_axi_wstrb = s;
    s_axi_wvalid = 1;
    for (int n = 0; n <= 100; n++) begin
      @(negedge clk);
      if (s_axi_wready) break;
      if (n == 100) check("w_timeout", 0, 1);
    end
    @(negedge clk);
    s_axi_wvalid = 0;
  endtask
  task automatic drive_ar(input logic [AW-1:0] a);
    s_axi_araddr = a;
    s_axi_arvalid = 1;
    last_ar_n = 0;
    for (int n = 0; n <= 100; n++) begin
      @(negedge clk);
      if (s_axi_arready) break;
      last_ar_n++;
      if (n == 100) check("ar_timeout", 0, 1);
    end
    @(negedge clk);
    s_axi_arvalid = 0;
    last_rv = s_axi_rvalid;
  endtask
  task automatic expect_write(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] s);
    exp_writes++;
    if (mapped(a)) begin
      model[a[3:2]] = merge(model[a[3:2]], d, s);
      exp_stb[a[3:2]]++;
      exp_b_q.push_back(2'b00);
    end else exp_b_q.push_back(2'b10);
  endtask
  task automatic expect_read(input logic [AW-1:0] a);
    if (mapped(a)) exp_r_q.push_back({2'b00, model[a[3:2]]});
    else exp_r_q.push_back({2'b10, 32'h0});
  endtask
  task automatic wait_b();
    for (int n = 0; n < 200 && exp_b_q.size() != 0; n++) @(negedge clk);
    if (exp_b_q.size() != 0) begin
      check("b_timeout", exp_b_q.size(), 0);
      exp_b_q.delete();
    end
    @(negedge clk);
  endtask
  task automatic wait_r();
    for (int n = 0; n < 200 && exp_r_q.size() != 0; n++) @(negedge clk);
    if (exp_r_q.size() != 0) begin
      check("r_timeout", exp_r_q.size(), 0);
      exp_r_q.delete();
    end
    @(negedge clk);
  endtask
  task automatic do_write(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] s, input int ad, input int wd);
    expect_write(a, d, s);
    fork
      drive_aw(a, ad);
      drive_w(d, s, wd);
    join
    wait_b();
  endtask
  task automatic do_read(input logic [AW-1:0] a);
    expect_read(a);
    drive_ar(a);
    wait_r();
  endtask
  task automatic wait_sig(input string name, input bit want_b);
    for (int n = 0; n <= 50; n++) begin
      if (want_b ? s_axi_bvalid : s_axi_rvalid) break;
      if (n == 50) check(name, 0, 1);
      @(negedge clk);
    end
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d of %0d checks", errors, checks);
    $fatal(1);
  end
  initial begin
    int b0, s0;
    for (int i = 0; i < 4; i++) begin model[i] = 0; stb_cnt[i] = 0; exp_stb[i] = 0; end
    repeat (3) @(negedge clk);
    check("rst_reg_q", reg_q, 0);
    check("rst_valids", {s_axi_bvalid, s_axi_rvalid, s_axi_awready, s_axi_wready, s_axi_arready}, 0);
    check("rst_resp_data", {s_axi_bresp, s_axi_rresp, s_axi_rdata, reg_wr_stb}, 0);
    rst = 0;
    @(negedge clk);
    for (int i = 0; i < 4; i++) do_write(AW'(4 * i), 32'(i + 1), 4'hF, 0, 0);
    check("basic_reg_q", reg_q, 128'h00000004_00000003_00000002_00000001);
    do_read(AW'(0));
    check("rd_latency", {last_ar_n[7:0], last_rv}, {8'd0, 1'b1});
    for (int i = 1; i < 4; i++) do_read(AW'(4 * i));
    b0 = b_rise;
    s0 = stb_cnt[2];
    do_write(AW'(8), 32'h0000_00A0, 4'hF, 2, 0);
    do_write(AW'(8), 32'h0000_00B0, 4'hF, 0, 2);
    check("order_brise", b_rise - b0, 2);
    check("order_stb2", stb_cnt[2] - s0, 2);
    do_read(AW'(8));
    do_write(AW'(4), 32'hAABBCCDD, 4'hF, 0, 0);
    do_write(AW'(4), 32'h11223344, 4'b0101, 1, 0);
    check("wstrb_reg1", reg_q[63:32], 32'hAA22CC44);
    do_read(AW'(4));
    do_write(AW'(12), 32'h1234_0000, 4'h0, 0, 0);
    check("zero_strb_reg3", reg_q[127:96], 32'h4);
    s_axi_bready = 0;
    expect_write(AW'(12), 32'h5A5A0003, 4'hF);
    fork
      drive_aw(AW'(12), 0);
      drive_w(32'h5A5A0003, 4'hF, 0);
    join
    wait_sig("stall_bvalid_timeout", 1);
    expect_write(AW'(4), 32'h0000_0077, 4'hF);
    fork
      drive_aw(AW'(4), 0);
      drive_w(32'h0000_0077, 4'hF, 0);
    join_none
    fork
      for (int i = 0; i < 10; i++) begin
        @(negedge clk);
        check("stall_ready_bvalid", {s_axi_awready, s_axi_wready, s_axi_bvalid}, 3'b001);
      end
      do_read(AW'(0));
    join
    s_axi_bready = 1;
    wait_b();
    check("stall_reg_q", reg_q[127:96], 32'h5A5A0003);
    check("stall_reg1", reg_q[63:32], 32'h77);
    s_axi_bready = 0;
    s_axi_rready = 0;
    expect_write(AW'(0), 32'h1234_5678, 4'hF);
    fork
      drive_aw(AW'(0), 0);
      drive_w(32'h1234_5678, 4'hF, 0);
    join
    wait_sig("rst_bvalid_timeout", 1);
    expect_read(AW'(8));
    drive_ar(AW'(8));
    wait_sig("rst_rvalid_timeout", 0);
    rst = 1;
    @(negedge clk);
    check("midrst_valids", {s_axi_bvalid, s_axi_rvalid}, 0);
    check("midrst_reg_q", reg_q, 0);
    rst = 0;
    exp_b_q.delete();
    exp_r_q.delete();
    for (int i = 0; i < 4; i++) model[i] = 0;
    s_axi_bready = 1;
    s_axi_rready = 1;
    @(negedge clk);
    do_read(AW'(0));
    do_write(AW'(6'h10), 32'h0000DEAD, 4'hF, 0, 0);
    check("hi_addr_reg0", reg_q[31:0], model[0]);
    do_read(AW'(6'h10));
    for (int k = 0; k < 40; k++) begin
      logic [AW-1:0] a = AW'($urandom_range(0, 63));
      if ($urandom_range(0, 1) == 1) do_write(a, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 3), $urandom_range(0, 3));
      else do_read(a);
    end
    for (int i = 0; i < 4; i++) check("final_reg", reg_q[32*i +: 32], model[i]);
    for (int i = 0; i < 4; i++) check("final_stb_count", stb_cnt[i], exp_stb[i]);
    check("final_brise", b_rise, exp_writes);
    check("final_queues", exp_b_q.size() + exp_r_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
